// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory target with a fixed, programmable
// response latency. One load/store in flight; RV32 sub-word access by funct3.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// are rejected with rsp_err instead of ignoring the low address bits.
module dmem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  state_t        state;
  state_t        next_state;
  req_t          cap;
  req_t          src_c;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          accept_c;
  logic          enter_resp_c;
  logic [31:0]   offset_c;
  logic [31:0]   woff_c;
  logic [AW-1:0] idx_c;
  logic          range_err_c;
  logic          funct3_err_c;
  logic          misalign_err_c;
  logic          err_c;
  logic [31:0]   word_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c;
  logic [3:0]    be_c;
  logic [31:0]   wlane_c;

  logic          ready_d;
  logic          valid_d;
  logic          err_d;
  logic [31:0]   rdata_d;

  assign accept_c     = req_valid & req_ready & (state == ST_IDLE);
  assign enter_resp_c = (next_state == ST_RESP) && (state != ST_RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept_c) next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == CW'(1)) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      cap <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
      cnt <= CNT_INIT;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Access source: live inputs when the accept edge is also the RESP-entry edge
  always_comb begin
    if (state == ST_IDLE)
      src_c = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
    else
      src_c = cap;
  end

  // Address decode and error classification
  always_comb begin
    offset_c     = src_c.addr - BASE_ADDR;
    woff_c       = offset_c >> 2;
    idx_c        = AW'(woff_c);
    range_err_c  = (src_c.addr < BASE_ADDR) || (woff_c >= 32'(DEPTH));
    if (src_c.we)
      funct3_err_c = !(src_c.funct3 inside {3'b000, 3'b001, 3'b010});
    else
      funct3_err_c = !(src_c.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_err_c = ((src_c.funct3[1:0] == 2'b01) && src_c.addr[0]) ||
                     ((src_c.funct3[1:0] == 2'b10) && (src_c.addr[1:0] != 2'b00));
`else
    misalign_err_c = 1'b0;
`endif
    err_c = range_err_c | funct3_err_c | misalign_err_c;
  end

  // Load extraction and store lane formatting
  always_comb begin
    word_c  = mem[idx_c];
    byte_c  = 8'(word_c >> {src_c.addr[1:0], 3'b000});
    half_c  = src_c.addr[1] ? word_c[31:16] : word_c[15:0];
    load_c  = '0;
    be_c    = '0;
    wlane_c = '0;
    case (src_c.funct3)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'h0, byte_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = '0;
    endcase
    case (src_c.funct3)
      3'b000: begin
        be_c    = 4'(4'b0001 << src_c.addr[1:0]);
        wlane_c = {4{src_c.wdata[7:0]}};
      end
      3'b001: begin
        be_c    = src_c.addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{src_c.wdata[15:0]}};
      end
      3'b010: begin
        be_c    = 4'b1111;
        wlane_c = src_c.wdata;
      end
      default: begin
        be_c    = '0;
        wlane_c = '0;
      end
    endcase
  end

  // Store commit on the RESP-entry edge; array is never cleared
  always_ff @(posedge clk) begin
    if (enter_resp_c && src_c.we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  // Output next-values
  always_comb begin
    ready_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if ((state == ST_IDLE) && !accept_c) ready_d = 1'b1;
    if (enter_resp_c) begin
      valid_d = 1'b1;
      err_d   = err_c;
      if (!err_c && !src_c.we) rdata_d = load_c;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_err   <= err_d;
      rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 (LATENCY=2, base 0) and instance 1
// (LATENCY=1, base 0x1000) share the request payload and clock.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        r_we = 1'b0;
  logic [31:0] r_addr = '0, r_wdata = '0;
  logic [2:0]  r_f3 = '0;
  logic        ready0, ready1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_m [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_we(r_we), .req_addr(r_addr), .req_wdata(r_wdata), .req_funct3(r_f3),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(r_we), .req_addr(r_addr), .req_wdata(r_wdata), .req_funct3(r_f3),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1));

  function automatic logic rdy(input int sel);
    return (sel == 1) ? ready1 : ready0;
  endfunction
  function automatic logic vld(input int sel);
    return (sel == 1) ? rv1 : rv0;
  endfunction
  function automatic logic [31:0] rdat(input int sel);
    return (sel == 1) ? rd1 : rd0;
  endfunction
  function automatic logic erf(input int sel);
    return (sel == 1) ? err1 : err0;
  endfunction

  // Reference: byte-addressed memory semantics of RV32 loads/stores
  function automatic void model_access(input int sel, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] f3,
                                       output logic [31:0] rd, output logic err);
    logic [31:0] base, w;
    logic [7:0]  b;
    logic [15:0] h;
    int unsigned idx;
    int bo;
    bit legal;
    base = (sel == 1) ? BASE1 : BASE0;
    rd = '0;
    err = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) err = 1'b1;
    if (addr < base) err = 1'b1;
    else if ((addr - base) / 4 >= DEPTH) err = 1'b1;
    bo = int'(addr % 4);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (bo % 2) != 0) err = 1'b1;
    if (f3 == 3'd2 && bo != 0) err = 1'b1;
`endif
    if (err) return;
    idx = (addr - base) / 4;
    if (we) begin
      case (f3)
        3'd0: mem_m[sel][idx][8*bo +: 8] = wdata[7:0];
        3'd1: mem_m[sel][idx][16*(bo/2) +: 16] = wdata[15:0];
        default: mem_m[sel][idx] = wdata;
      endcase
    end else begin
      w = mem_m[sel][idx];
      b = w[8*bo +: 8];
      h = w[16*(bo/2) +: 16];
      case (f3)
        3'd0: rd = {{24{b[7]}}, b};
        3'd1: rd = {{16{h[15]}}, h};
        3'd2: rd = w;
        3'd4: rd = {24'h0, b};
        default: rd = {16'h0, h};
      endcase
    end
  endfunction

  // One full transaction with handshake timing and response checks
  task automatic txn(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic exp_err;
    int n, lat;
    lat = (sel == 1) ? LAT1 : LAT0;
    model_access(sel, we, addr, wdata, f3, exp_rd, exp_err);
    got_rd = '0;
    got_err = 1'b0;
    r_we = we; r_addr = addr; r_wdata = wdata; r_f3 = f3;
    if (sel == 1) valid1 = 1'b1; else valid0 = 1'b1;
    n = 0;
    while (!rdy(sel) && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (!rdy(sel)) begin
      n_fail++;
      $display("FAIL accept_timeout: inst %0d req_ready=%b after %0d cycles, required 1", sel, rdy(sel), n);
      valid0 = 1'b0; valid1 = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vld(sel) !== (k == lat)) begin
        n_fail++;
        $display("FAIL rsp_valid_timing: inst %0d cycle %0d got %b required %b", sel, k, vld(sel), (k == lat));
      end
      n_cmp++;
      if (rdy(sel) !== (k == lat + 2)) begin
        n_fail++;
        $display("FAIL req_ready_timing: inst %0d cycle %0d got %b required %b", sel, k, rdy(sel), (k == lat + 2));
      end
      if (k == lat) begin
        got_rd = rdat(sel);
        got_err = erf(sel);
        n_cmp++;
        if (got_rd !== exp_rd) begin
          n_fail++;
          $display("FAIL rsp_rdata: inst %0d we=%b addr=%h f3=%0d got %h required %h", sel, we, addr, f3, got_rd, exp_rd);
        end
        n_cmp++;
        if (got_err !== exp_err) begin
          n_fail++;
          $display("FAIL rsp_err: inst %0d we=%b addr=%h f3=%0d got %b required %b", sel, we, addr, f3, got_err, exp_err);
        end
      end else begin
        n_cmp++;
        if (rdat(sel) !== 32'h0 || erf(sel) !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_rsp_zero: inst %0d cycle %0d got rdata=%h err=%b required 0/0", sel, k, rdat(sel), erf(sel));
        end
      end
      if (k <= lat + 1) begin
        r_we = 1'($urandom); r_addr = $urandom; r_wdata = $urandom; r_f3 = 3'($urandom);
      end
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready0, rv0, err0, rd0} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs0: got ready=%b valid=%b err=%b rdata=%h required all 0", ready0, rv0, err0, rd0);
    end
    n_cmp++;
    if ({ready1, rv1, err1, rd1} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs1: got ready=%b valid=%b err=%b rdata=%h required all 0", ready1, rv1, err1, rd1);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b required 0", ready0);
    end
    @(negedge clk);
    n_cmp++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b%b required 11", ready0, ready1);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 16; i++) begin
      txn(0, 1'b1, BASE0 + 32'(4 * i), $urandom, 3'd2, rd, er);
      txn(1, 1'b1, BASE1 + 32'(4 * i), $urandom, 3'd2, rd, er);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic er;
    txn(0, 1'b1, 32'h80, 32'hDEADBEEF, 3'd2, rd, er);
    txn(0, 1'b0, 32'h80, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lw: got %h err=%b required deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    logic er;
    txn(0, 1'b1, 32'h80, 32'h11223344, 3'd2, rd, er);
    txn(0, 1'b1, 32'h81, 32'h000000F0, 3'd0, rd, er);
    txn(0, 1'b0, 32'h80, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (rd !== 32'h1122F044) begin n_fail++; $display("FAIL sb_lw: got %h required 1122f044", rd); end
    txn(0, 1'b0, 32'h81, 32'h0, 3'd0, rd, er);
    n_cmp++;
    if (rd !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb: got %h required fffffff0", rd); end
    txn(0, 1'b0, 32'h81, 32'h0, 3'd4, rd, er);
    n_cmp++;
    if (rd !== 32'h000000F0) begin n_fail++; $display("FAIL lbu: got %h required 000000f0", rd); end
    txn(0, 1'b0, 32'h82, 32'h0, 3'd1, rd, er);
    n_cmp++;
    if (rd !== 32'h00001122) begin n_fail++; $display("FAIL lh: got %h required 00001122", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    txn(0, 1'b0, 32'h400, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL range_err: got err=%b rdata=%h required 1/0", er, rd);
    end
    txn(0, 1'b1, 32'h80, 32'hA5A5A5A5, 3'd4, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL store_f3_err: got %b required 1", er); end
    txn(0, 1'b0, 32'h80, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (rd !== 32'h1122F044) begin n_fail++; $display("FAIL store_f3_nowrite: got %h required 1122f044", rd); end
    txn(0, 1'b0, 32'h80, 32'h0, 3'd6, rd, er);
    txn(1, 1'b0, 32'h0FFC, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL below_base_err: got %b required 1", er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic er;
    txn(0, 1'b0, 32'h82, 32'h0, 3'd2, rd, er);
    n_cmp++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_lw: got err=%b rdata=%h required 1/0", er, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'h1122F044) begin
      n_fail++;
      $display("FAIL misalign_lw: got err=%b rdata=%h required 0/1122f044", er, rd);
    end
`endif
    txn(0, 1'b1, 32'h83, 32'h0000ABCD, 3'd1, rd, er);
    n_cmp++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_sh: got err=%b required 1", er); end
`else
    if (er !== 1'b0) begin n_fail++; $display("FAIL misalign_sh: got err=%b required 0", er); end
`endif
    txn(0, 1'b0, 32'h80, 32'h0, 3'd2, rd, er);
    txn(0, 1'b0, 32'h81, 32'h0, 3'd5, rd, er);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 6; i++) begin
      txn(0, 1'($urandom), BASE0 + 32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 2)), rd, er);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd;
    logic er;
    txn(1, 1'b1, BASE1 + 32'h84, 32'hCAFE1234, 3'd2, rd, er);
    txn(1, 1'b0, BASE1 + 32'h86, 32'h0, 3'd1, rd, er);
    n_cmp++;
    if (rd !== 32'hFFFFCAFE) begin n_fail++; $display("FAIL lat1_lh: got %h required ffffcafe", rd); end
    txn(1, 1'b0, BASE1 + 32'h84, 32'h0, 3'd2, rd, er);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic er;
    int n;
    txn(0, 1'b1, 32'h90, 32'hCAFEF00D, 3'd2, rd, er);
    r_we = 1'b1; r_addr = 32'h90; r_wdata = 32'h55; r_f3 = 3'd2;
    valid0 = 1'b1;
    n = 0;
    while (!ready0 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rv0 !== 1'b0 || ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b ready=%b required 0/0", rv0, ready0);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rv0 !== 1'b0) begin
        n_fail++;
        $display("FAIL aborted_rsp: cycle %0d got rsp_valid=%b required 0", k, rv0);
      end
    end
    txn(0, 1'b0, 32'h90, 32'h0, 3'd2, rd, er);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL aborted_store: got %h required cafef00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, base;
    logic er, we;
    logic [2:0] f3;
    int sel, pick;
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 1));
      base = (sel == 1) ? BASE1 : BASE0;
      we = 1'($urandom);
      pick = int'($urandom_range(0, 9));
      if (pick < 8) addr = base + 32'($urandom_range(0, 63));
      else if (pick == 8) addr = base + 32'h400 + 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 32'h0FFF));
      pick = int'($urandom_range(0, 9));
      if (pick < 8) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      else f3 = 3'($urandom);
      txn(sel, we, addr, $urandom, f3, rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_subword();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_latency1();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's memory-stage read/write interface.
- Replaces the zero-latency data memory with a handshaked, multi-cycle target that has a fixed, programmable response latency.
- Accepts one load/store at a time, performs the RV32 sub-word access selected by funct3, and returns data plus an error flag.
- Core-side initiator holds its request until `req_ready` and waits for `rsp_valid`.

Parameters:
- DEPTH, 256, number of 32-bit words stored (power of two).
- LATENCY, 2, cycles from request accept edge to `rsp_valid` high; legal 1..15.
- BASE_ADDR, 32'h0, byte address of word 0; word index = (req_addr - BASE_ADDR) >> 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the LSBs are used for sb/sh.
- req_funct3  in  3  RV32 load/store funct3.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and on error.
- rsp_err  out  1  valid with rsp_valid; access rejected.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - req_ready rises on the first clk edge after rst_n deasserts.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On the edge with req_valid & req_ready: capture we/addr/wdata/funct3 and set counter = LATENCY-1.
  - Go to RESP if LATENCY == 1, else WAIT.
  - req_ready drops to 0 the same edge.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter == 1, go to RESP.
- Entering RESP (same edge): perform the access.
  - Store commits to the array here.
  - rsp_rdata/rsp_err are registered here.
  - rsp_valid = 1 for exactly one cycle; there is no response backpressure.
- RESP always returns to IDLE on the next edge.
  - rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0 in all states other than RESP.
  - Earliest next accept is the edge after rsp_valid falls. A new request is therefore accepted at most every LATENCY+2 cycles.
- Inputs are sampled only at accept; changes while busy are ignored. req_valid outside IDLE has no effect.
- Loads:
  - 000 lb: sign-extend byte addr[1:0].
  - 001 lh: sign-extend half addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
- Stores:
  - 000 sb: write byte lane addr[1:0].
  - 001 sh: write half lane addr[1].
  - 010 sw: write full word.
  - Other lanes are untouched.
- Errors (rsp_err = 1, no write, rsp_rdata = 0):
  - Word index >= DEPTH.
  - req_addr < BASE_ADDR.
  - Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010).
- Misalignment without the macro: low address bits are ignored.
  - lh/sh use addr[1] only.
  - lw/sw ignore addr[1:0].
- Reset mid-operation (WAIT or RESP): transaction aborted, no response issued.
  - A store whose RESP-entry edge has not occurred is not committed.
- Load of a location written by the immediately previous store returns the new data.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned accesses (lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] != 0) give rsp_err = 1, rsp_rdata = 0, and no write.
- Undefined: low-bit-ignore behaviour above; rsp_err only on range/funct3 errors.

Test Plan:
- LATENCY=2: reset, then sw addr 0x80 data 0xDEADBEEF, then lw 0x80.
  - Each rsp_valid is high exactly 2 cycles after its accept edge.
  - lw returns 0xDEADBEEF with rsp_err = 0.
- Sub-word: sb 0x81 data 0x000000F0 over word 0x11223344.
  - lw returns 0x1122F044.
  - lb 0x81 returns 0xFFFFFFF0; lbu 0x81 returns 0x000000F0.
  - lh 0x82 returns 0x00001122.
- Range and funct3 errors:
  - lw 0x400 (DEPTH=256): rsp_err = 1, rsp_rdata = 0.
  - Store with funct3 = 100: rsp_err = 1, memory unchanged.
- Misalign: lw 0x82.
  - Without macro: returns word at 0x80, rsp_err = 0.
  - With DMEM_MISALIGN_TRAP_EN: rsp_err = 1, rsp_rdata = 0.
  - sh 0x83 is rejected with the macro defined.
- Handshake:
  - req_valid held high continuously: req_ready low for LATENCY+1 cycles per transaction.
  - Mid-transaction input changes do not alter the response.
  - LATENCY=1 gives rsp_valid on the cycle right after accept.
- Reset mid-WAIT during sw 0x90 data 0x55: rsp_valid is never asserted, and later lw 0x90 returns the pre-store value.
